// File: rtl/addsub_serial_pkg.sv
// Shared op encodings, FSM state type and flag helper for the digit-serial add/subtract unit.
package addsub_serial_pkg;

  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Signed overflow: SUB/CMP overflow needs differing operand signs, ADD needs equal ones.
  function automatic logic signed_ovf(input logic sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    return (sub ? (a_msb != b_msb) : (a_msb == b_msb)) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-wide ripple slice; subtract is a + ~b + ~borrow with the carry
// inverted back into a borrow, so one adder serves both operations.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [DIGIT-1:0] res,
  output logic             cout
);

  logic [DIGIT:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b ^ {DIGIT{sub}}} + {{DIGIT{1'b0}}, cin ^ sub};
    res  = sum[DIGIT-1:0];
    cout = sum[DIGIT] ^ sub;
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial SUB/ADD/CMP unit: result valid WIDTH/DIGIT cycles after capture;
// holds the result in DONE until out_ready, accepting no new operands meanwhile.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             a_msb, b_msb, is_sub, is_cmp, cy;
  logic [DIGIT-1:0] dig_res;
  logic             dig_cout;
  logic [WIDTH-1:0] dig_ext, res_nxt;
  logic             capture, finish;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .cin  (cy),
    .sub  (is_sub),
    .res  (dig_res),
    .cout (dig_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    finish    = 1'b0;
    in_ready  = rst_n && (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          capture   = 1'b1;
          state_nxt = ST_RUN;
        end
        ST_RUN: if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end
        ST_DONE: if (out_ready) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // New digit enters at the MSB end; after NDIG shifts the result is LSB-aligned.
  always_comb begin
    dig_ext              = '0;
    dig_ext[DIGIT-1:0]   = dig_res;
    res_nxt              = (res_sr >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      is_sub   <= 1'b0;
      is_cmp   <= 1'b0;
      cy       <= 1'b0;
      out_res  <= '0;
      out_cout <= 1'b0;
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (capture) begin
      cnt    <= '0;
      a_sr   <= in_a;
      b_sr   <= in_b;
      res_sr <= '0;
      a_msb  <= in_a[WIDTH-1];
      b_msb  <= in_b[WIDTH-1];
      is_sub <= (in_op != OP_ADD);
      is_cmp <= (in_op == OP_CMP);
      cy     <= in_cin;
    end else if (state == ST_RUN && !abort) begin
      cnt    <= cnt + CW'(1);
      a_sr   <= a_sr >> DIGIT;
      b_sr   <= b_sr >> DIGIT;
      res_sr <= res_nxt;
      cy     <= dig_cout;
      if (finish) begin
        // Zero/neg/ovf come from the true difference even when CMP masks the result.
        out_res  <= is_cmp ? '0 : res_nxt;
        out_cout <= dig_cout;
        out_zero <= (res_nxt == '0);
        out_neg  <= res_nxt[WIDTH-1];
        out_ovf  <= signed_ovf(is_sub, a_msb, b_msb, res_nxt[WIDTH-1]);
      end
    end
  end

endmodule
